// File: rtl/fft_addgen.sv
`default_nettype none
// ============================================================================
// Module   : fft_addgen
// Purpose  : Address generator / sequencer for an in-place radix-2 FFT of
//            2^LEVEL points using ping-pong data memories. Walks LEVEL levels
//            of 2^(LEVEL-1) butterflies, presenting both data addresses, the
//            twiddle ROM address and the RAM read/write selects each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module fft_addgen #(
    parameter int BIT_WIDTH = 16,   // datapath width, interface consistency only
    parameter int LEVEL     = 9     // log2(FFT length)
) (
    input  logic             clk,
    input  logic             reset,       // asynchronous, active-low
    input  logic             fft_enable,
    output logic [LEVEL-1:0] add_a,
    output logic [LEVEL-1:0] add_b,
    output logic [LEVEL-2:0] add_tw,
    output logic             mem_write0,
    output logic             mem_write1,
    output logic             read_sel,
    output logic             fft_done
);

    localparam int                 c_BF_W     = LEVEL - 1;
    localparam int                 c_LVL_W    = $clog2(LEVEL + 1);
    localparam logic [c_BF_W-1:0]  c_BF_MAX   = '1;
    localparam logic [c_LVL_W-1:0] c_LVL_DONE = c_LVL_W'(LEVEL);
    localparam logic [c_LVL_W-1:0] c_LVL_LAST = c_LVL_W'(LEVEL - 1);

    // Reject parameterisations the address arithmetic cannot support.
    if (LEVEL < 2 || BIT_WIDTH < 1) begin : g_param_check
        $error("fft_addgen: LEVEL must be >= 2 and BIT_WIDTH >= 1");
    end

    logic [c_BF_W-1:0]  r_fft_bf;
    logic [c_LVL_W-1:0] r_fft_level;
    logic               w_done;
    logic               w_step;
    logic [LEVEL-1:0]   w_a;
    logic [LEVEL-1:0]   w_b;
    logic [c_LVL_W-1:0] w_rot_back;
    logic [c_BF_W-1:0]  w_tw_mask;

    assign w_done = (r_fft_level == c_LVL_DONE);
    assign w_step = fft_enable & ~w_done;

    // Butterfly/level counters: butterfly wraps into the next level; frozen once done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fft_bf    <= '0;
            r_fft_level <= '0;
        end else if (w_step) begin
            if (r_fft_bf == c_BF_MAX) begin
                r_fft_bf    <= '0;
                r_fft_level <= r_fft_level + c_LVL_W'(1);
            end else begin
                r_fft_bf <= r_fft_bf + c_BF_W'(1);
            end
        end
    end

    // Butterfly pair before rotation: even/odd neighbours.
    assign w_a = {r_fft_bf, 1'b0};
    assign w_b = {r_fft_bf, 1'b1};

    // Rotate-left by the level; level 0 and level LEVEL both give identity
    // because one of the two shift terms then shifts everything out.
    assign w_rot_back = c_LVL_DONE - r_fft_level;
    assign add_a      = (w_a << r_fft_level) | (w_a >> w_rot_back);
    assign add_b      = (w_b << r_fft_level) | (w_b >> w_rot_back);

    // Twiddle mask keeps the top 'level' bits of the butterfly index; at the
    // last level (and in the done state) the full index passes through.
    always_comb begin
        w_tw_mask = c_BF_MAX;
        if (r_fft_level < c_LVL_LAST) begin
            w_tw_mask = c_BF_MAX << (c_LVL_LAST - r_fft_level);
        end
    end

    assign add_tw = r_fft_bf & w_tw_mask;

    // Ping-pong: even levels read RAM0 / write RAM1, odd levels the reverse.
    assign read_sel   = r_fft_level[0];
    assign mem_write0 =  r_fft_level[0] & w_step;
    assign mem_write1 = ~r_fft_level[0] & w_step;
    assign fft_done   = w_done;

endmodule
`default_nettype wire

// File: tb/tb_fft_addgen.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_addgen
// Purpose  : Scoreboard bench for fft_addgen. A driver applies random enables
//            and pushes the expected outputs from an arithmetic model of the
//            FFT schedule; a monitor pops and compares on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_addgen;

    localparam int N        = 9;
    localparam int HALF     = 1 << (N - 1);
    localparam int TOTAL    = N * HALF;              // 2304 enabled cycles
    localparam int PAUSE_K  = 3 * HALF + 'h40;       // level 3, bf 0x40
    localparam int RESET_K  = 5 * HALF + 'h80;       // level 5, bf 0x80
    localparam int MAX_CYC  = 20000;

    typedef struct {
        int a;
        int b;
        int tw;
        int rs;
        int mw0;
        int mw1;
        int done;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         fft_enable;
    logic [N-1:0] add_a;
    logic [N-1:0] add_b;
    logic [N-2:0] add_tw;
    logic         mem_write0;
    logic         mem_write1;
    logic         read_sel;
    logic         fft_done;

    int   checks   = 0;
    int   failures = 0;
    int   k        = 0;     // enabled steps taken since reset (model state)
    exp_t sb[$];

    fft_addgen #(.BIT_WIDTH(16), .LEVEL(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .fft_enable (fft_enable),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_tw     (add_tw),
        .mem_write0 (mem_write0),
        .mem_write1 (mem_write1),
        .read_sel   (read_sel),
        .fft_done   (fft_done)
    );

    always #5 clk = ~clk;

    // Rotate v left by r positions inside an N-bit word, bit by bit.
    function automatic int rotl(input int v, input int r);
        int o = 0;
        for (int i = 0; i < N; i++) begin
            if (((v >> i) & 1) == 1) o = o | (1 << ((i + r) % N));
        end
        return o;
    endfunction

    // Expected outputs after 'steps' enabled cycles with the given enable.
    function automatic exp_t model(input int steps, input bit en);
        exp_t e;
        int   lvl = steps / HALF;
        int   bf  = steps % HALF;
        e.a    = rotl(2 * bf, lvl);
        e.b    = rotl(2 * bf + 1, lvl);
        e.tw   = (lvl >= N - 1) ? bf : bf - (bf % (1 << (N - 1 - lvl)));
        e.rs   = lvl % 2;
        e.done = (lvl == N) ? 1 : 0;
        e.mw0  = ((lvl % 2 == 1) && en && e.done == 0) ? 1 : 0;
        e.mw1  = ((lvl % 2 == 0) && en && e.done == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (step %0d, t=%0t)",
                     nm, act, exp, k, $time);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        check({tag, "add_a"},      int'(add_a),      e.a);
        check({tag, "add_b"},      int'(add_b),      e.b);
        check({tag, "add_tw"},     int'(add_tw),     e.tw);
        check({tag, "read_sel"},   int'(read_sel),   e.rs);
        check({tag, "mem_write0"}, int'(mem_write0), e.mw0);
        check({tag, "mem_write1"}, int'(mem_write1), e.mw1);
        check({tag, "fft_done"},   int'(fft_done),   e.done);
    endtask

    // Monitor: compare every presented cycle against the scoreboard.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check_all("", e);
        end
    end

    // One cycle: entered and left at posedge+1.
    task automatic drive_cycle(input bit en);
        fft_enable = en;
        sb.push_back(model(k, en));
        @(posedge clk);
        #1;
        if (en && k < TOTAL) k++;
    endtask

    task automatic apply_reset();
        reset      = 1'b0;
        fft_enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        k     = 0;
    endtask

    task automatic run_to(input int target, input bit do_pause);
        int cyc   = 0;
        int pause = 0;
        while (k < target && cyc < MAX_CYC) begin
            bit en;
            en = ($urandom_range(0, 3) != 0);
            if (do_pause && k == PAUSE_K && pause < 10) begin
                en = 1'b0;
                pause++;
            end
            drive_cycle(en);
            cyc++;
        end
        if (k < target) check("run_budget_expired", k, target);
    endtask

    initial begin
        exp_t e;
        reset      = 1'b0;
        fft_enable = 1'b0;
        apply_reset();

        // Full transform with random enables and a 10-cycle pause mid-level 3.
        run_to(TOTAL, 1'b1);
        // Done is sticky: counters frozen and writes suppressed.
        repeat (20) drive_cycle(1'b1);
        drive_cycle(1'b0);

        // Second run, interrupted by an asynchronous reset at level 5.
        apply_reset();
        run_to(RESET_K, 1'b0);
        fft_enable = 1'b1;
        #2;
        check_all("pre_reset_", model(k, 1'b1));
        reset = 1'b0;
        #1;
        check_all("async_reset_", model(0, 1'b1));
        @(posedge clk);
        #1;
        check_all("held_reset_", model(0, 1'b1));
        reset = 1'b1;
        k     = 0;
        repeat (60) drive_cycle($urandom_range(0, 1) == 1);

        @(negedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
